// File: rtl/hub75_scan_ctrl.sv
// ============================================================================
// Module   : hub75_scan_ctrl
// Brief    : HUB75 row / bit-plane scan sequencer with binary-weighted OE time
// Revision : 1.0
// ============================================================================
`default_nettype none

module hub75_scan_ctrl #(
  parameter  int hpixel_p        = 64,
  parameter  int vpixel_p        = 64,
  parameter  int bpp_p           = 8,
  parameter  int segments_p      = 2,
  parameter  int clk_div_wd_p    = 8,
  parameter  int blank_cyc_p     = 2,
  localparam int rows_p          = vpixel_p / segments_p,
  localparam int row_wd_p        = $clog2(rows_p),
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  localparam int pix_bit_width_p = $clog2(bpp_p),
  localparam int oe_wd_p         = clk_div_wd_p + bpp_p
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [clk_div_wd_p-1:0]    i_oe_base,
  output logic                       o_tx_start,
  output logic [addr_width_p-1:0]    o_init_addr,
  output logic [pix_bit_width_p-1:0] o_pix_bit,
  input  logic                       i_tx_ready,
  output logic [row_wd_p-1:0]        o_row_addr,
  output logic                       o_oe_n,
  output logic                       o_frame_done,
  output logic                       o_busy
);

  localparam int blank_wd_p = (blank_cyc_p > 1) ? $clog2(blank_cyc_p) : 1;

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_tx_start = 3'd1;
  localparam logic [2:0] c_st_tx_wait  = 3'd2;
  localparam logic [2:0] c_st_blank    = 3'd3;
  localparam logic [2:0] c_st_show     = 3'd4;

  localparam logic [pix_bit_width_p-1:0] c_bit_last   = pix_bit_width_p'(bpp_p - 1);
  localparam logic [row_wd_p-1:0]        c_row_last   = row_wd_p'(rows_p - 1);
  localparam logic [blank_wd_p-1:0]      c_blank_load = blank_wd_p'(blank_cyc_p - 1);

  logic [2:0]                 r_state;
  logic [row_wd_p-1:0]        r_row;
  logic [pix_bit_width_p-1:0] r_bit;
  logic                       r_seen_low;
  logic [blank_wd_p-1:0]      r_blank_cnt;
  logic [oe_wd_p-1:0]         r_oe_cnt;

  logic                       w_last_bit;
  logic                       w_last_row;
  logic [pix_bit_width_p-1:0] w_bit_nxt;
  logic [row_wd_p-1:0]        w_row_nxt;
  logic                       w_start_ok;
  logic [clk_div_wd_p-1:0]    w_oe_base;
  logic [oe_wd_p-1:0]         w_oe_load;
  logic [addr_width_p-1:0]    w_cur_addr;
  logic [addr_width_p-1:0]    w_nxt_addr;

  always_comb begin
    w_last_bit = (r_bit == c_bit_last);
    w_last_row = (r_row == c_row_last);
    w_bit_nxt  = w_last_bit ? '0 : r_bit + pix_bit_width_p'(1);
    w_row_nxt  = r_row;
    if (w_last_bit) begin
      w_row_nxt = w_last_row ? '0 : r_row + row_wd_p'(1);
    end
    w_start_ok = i_enable && i_tx_ready;
    w_oe_base  = (i_oe_base == '0) ? clk_div_wd_p'(1) : i_oe_base;
    w_oe_load  = (oe_wd_p'(w_oe_base) << r_bit) - oe_wd_p'(1);
    w_cur_addr = addr_width_p'(r_row) * addr_width_p'(hpixel_p);
    w_nxt_addr = addr_width_p'(w_row_nxt) * addr_width_p'(hpixel_p);
  end

  // Shift parameters are loaded on entry to TX_START; the registered start
  // pulse follows one cycle later, so they are stable a cycle ahead of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_row        <= '0;
      r_bit        <= '0;
      r_seen_low   <= 1'b0;
      r_blank_cnt  <= '0;
      r_oe_cnt     <= '0;
      o_tx_start   <= 1'b0;
      o_init_addr  <= '0;
      o_pix_bit    <= '0;
      o_row_addr   <= '0;
      o_oe_n       <= 1'b1;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          o_oe_n <= 1'b1;
          if (w_start_ok) begin
            o_init_addr <= w_cur_addr;
            o_pix_bit   <= r_bit;
            o_busy      <= 1'b1;
            r_state     <= c_st_tx_start;
          end
        end
        c_st_tx_start: begin
          o_tx_start <= 1'b1;
          r_seen_low <= 1'b0;
          r_state    <= c_st_tx_wait;
        end
        c_st_tx_wait: begin
          o_oe_n <= 1'b1;
          if (!i_tx_ready) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_blank_cnt <= c_blank_load;
            r_state     <= c_st_blank;
          end
        end
        c_st_blank: begin
          o_oe_n     <= 1'b1;
          o_row_addr <= r_row;
          if (r_blank_cnt == '0) begin
            r_oe_cnt <= w_oe_load;
            o_oe_n   <= 1'b0;
            r_state  <= c_st_show;
          end else begin
            r_blank_cnt <= r_blank_cnt - blank_wd_p'(1);
          end
        end
        c_st_show: begin
          if (r_oe_cnt != '0) begin
            r_oe_cnt <= r_oe_cnt - oe_wd_p'(1);
          end else begin
            o_oe_n       <= 1'b1;
            r_bit        <= w_bit_nxt;
            r_row        <= w_row_nxt;
            o_frame_done <= w_last_bit && w_last_row;
            if (w_start_ok) begin
              o_init_addr <= w_nxt_addr;
              o_pix_bit   <= w_bit_nxt;
              r_state     <= c_st_tx_start;
            end else begin
              o_busy  <= 1'b0;
              r_state <= c_st_idle;
            end
          end
        end
        default: begin
          o_oe_n  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
// ============================================================================
// Module   : tb_hub75_scan_ctrl
// Brief    : Scoreboard bench for hub75_scan_ctrl with a start/ready shifter model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hub75_scan_ctrl;

  localparam int HPIX      = 64;
  localparam int ROWS      = 32;
  localparam int BPP       = 8;
  localparam int BLANK_CYC = 2;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  pbit;
  } start_t;

  typedef struct {
    int len;
    int row;
    bit last;
  } oe_t;

  logic        clk;
  logic        rst_n;
  logic        i_enable;
  logic [7:0]  i_oe_base;
  logic        o_tx_start;
  logic [11:0] o_init_addr;
  logic [2:0]  o_pix_bit;
  logic        i_tx_ready;
  logic [4:0]  o_row_addr;
  logic        o_oe_n;
  logic        o_frame_done;
  logic        o_busy;

  hub75_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_oe_base    (i_oe_base),
    .o_tx_start   (o_tx_start),
    .o_init_addr  (o_init_addr),
    .o_pix_bit    (o_pix_bit),
    .i_tx_ready   (i_tx_ready),
    .o_row_addr   (o_row_addr),
    .o_oe_n       (o_oe_n),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_checks = 0;
  int     n_fail   = 0;
  start_t q_start[$];
  oe_t    q_oe[$];
  int     m_row = 0;
  int     m_bit = 0;
  int     pushed_cnt = 0;
  int     starts_cnt = 0;
  int     frames_cnt = 0;
  int     exp_frames = 0;
  int     low_cnt = 0;
  int     rdy_cyc = 0;
  int     lat = 100;
  bit     hold_low = 0;
  bit     row_bad = 0;
  oe_t    cur;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_planes(input int n);
    start_t s;
    oe_t    e;
    int     eff;
    eff = (i_oe_base == 8'd0) ? 1 : int'(i_oe_base);
    for (int k = 0; k < n; k++) begin
      s.addr = 12'(m_row * HPIX);
      s.pbit = 3'(m_bit);
      e.len  = eff << m_bit;
      e.row  = m_row;
      e.last = (m_row == ROWS - 1) && (m_bit == BPP - 1);
      if (e.last) exp_frames++;
      q_start.push_back(s);
      q_oe.push_back(e);
      pushed_cnt++;
      m_bit++;
      if (m_bit == BPP) begin
        m_bit = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end
    end
  endtask

  // Lets the pushed planes play out, drops enable during the last SHOW and
  // waits for the sequencer to park in IDLE.
  task automatic finish_run();
    bit ok;
    ok = 0;
    for (int t = 0; t < 60000; t++) begin
      @(negedge clk); #1;
      if (q_start.size() == 0 && q_oe.size() == 0 && low_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    check_eq("run_reach_last", 32'(ok), 1);
    i_enable = 1'b0;
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk); #1;
      if (low_cnt == 0 && !o_busy) begin
        ok = 1;
        break;
      end
    end
    check_eq("idle_after_stop", 32'(ok), 1);
    check_eq("start_count", 32'(starts_cnt), 32'(pushed_cnt));
  endtask

  // Shifter model: ready drops right after a start pulse, returns lat cycles later.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        i_tx_ready = 1'b1;
      end else if (hold_low) begin
        i_tx_ready = 1'b0;
      end else if (o_tx_start) begin
        i_tx_ready = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        i_tx_ready = 1'b1;
        rdy_cyc = cyc;
      end else if (!i_tx_ready) begin
        i_tx_ready = 1'b1;
        rdy_cyc = cyc;
      end
    end
  end

  // Output monitor: start pulses against the start queue, OE bursts against the OE queue.
  initial begin
    start_t s;
    cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_cnt = 0;
      end else begin
        if (o_tx_start) begin
          starts_cnt++;
          check_eq("start_oe_off", 32'(o_oe_n), 1);
          check_eq("start_expected", 32'(q_start.size() != 0), 1);
          if (q_start.size() != 0) begin
            s = q_start.pop_front();
            check_eq("init_addr", 32'(o_init_addr), 32'(s.addr));
            check_eq("pix_bit", 32'(o_pix_bit), 32'(s.pbit));
          end
        end
        if (o_frame_done) frames_cnt++;
        if (!o_oe_n) begin
          if (low_cnt == 0) begin
            check_eq("blank_gap", 32'(cyc - rdy_cyc), BLANK_CYC + 1);
            check_eq("oe_expected", 32'(q_oe.size() != 0), 1);
            if (q_oe.size() != 0) cur = q_oe.pop_front();
            else cur = '{0, 0, 0};
            row_bad = 0;
          end
          low_cnt++;
          if (int'(o_row_addr) != cur.row) row_bad = 1;
        end else if (low_cnt > 0) begin
          check_eq("oe_len", 32'(low_cnt), 32'(cur.len));
          check_eq("row_stable", 32'(row_bad), 0);
          check_eq("frame_done_at_end", 32'(o_frame_done), 32'(cur.last));
          low_cnt = 0;
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    i_enable  = 1'b0;
    i_oe_base = 8'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_start", 32'(o_tx_start), 0);
    check_eq("rst_init_addr", 32'(o_init_addr), 0);
    check_eq("rst_pix_bit", 32'(o_pix_bit), 0);
    check_eq("rst_row_addr", 32'(o_row_addr), 0);
    check_eq("rst_oe_n", 32'(o_oe_n), 1);
    check_eq("rst_frame_done", 32'(o_frame_done), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    #1 rst_n = 1'b1;

    // Row 0 at base 4 with a slow shifter, plus the first plane of row 1.
    lat = 100;
    push_planes(9);
    i_enable = 1'b1;
    finish_run();

    // Rest of the frame with base 0, wrapping into row 0 again.
    lat = 4;
    i_oe_base = 8'd0;
    push_planes(ROWS * BPP - 9 + 2);
    i_enable = 1'b1;
    finish_run();
    check_eq("frame_count", 32'(frames_cnt), 32'(exp_frames));

    // Stop after row 3 plane 2, then hold the shifter busy before resuming.
    i_oe_base = 8'd3;
    push_planes(25);
    i_enable = 1'b1;
    finish_run();
    hold_low = 1;
    repeat (2) @(posedge clk);
    push_planes(1);
    @(negedge clk); #1;
    i_enable = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("hold_busy", 32'(o_busy), 0);
    check_eq("hold_no_start", 32'(starts_cnt), 32'(pushed_cnt - 1));
    hold_low = 0;
    finish_run();

    // Reset in the middle of a SHOW.
    i_oe_base = 8'd20;
    push_planes(1);
    i_enable = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int t = 0; t < 5000; t++) begin
        @(negedge clk); #1;
        if (low_cnt > 5) begin
          ok = 1;
          break;
        end
      end
      check_eq("show_before_reset", 32'(ok), 1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_oe_n", 32'(o_oe_n), 1);
    check_eq("abort_row_addr", 32'(o_row_addr), 0);
    check_eq("abort_tx_start", 32'(o_tx_start), 0);
    check_eq("abort_busy", 32'(o_busy), 0);
    q_start.delete();
    q_oe.delete();
    m_row = 0;
    m_bit = 0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold_no_start", 32'(o_tx_start), 0);
    end
    push_planes(2);
    #1 rst_n = 1'b1;
    finish_run();
    check_eq("frame_count_end", 32'(frames_cnt), 32'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
